// File: rtl/div_seq_ctrl.sv
// rtl/div_seq_ctrl.sv - MIPS DIV/DIVU sequencer around a 32-cycle unsigned divider core
// Handles sign magnitude conversion, core launch/wait with timeout, sign fix-up and HI/LO write.
module div_seq_ctrl #(
    parameter int TIMEOUT = 40
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        op_valid,
    input  logic        op_signed,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        flush,
    output logic        core_start,
    output logic [31:0] core_dividend,
    output logic [31:0] core_divisor,
    input  logic        core_busy,
    input  logic [31:0] core_q,
    input  logic [31:0] core_r,
    output logic        stall,
    output logic        hilo_we,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out,
    output logic        div_err
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LAUNCH = 3'd1,
        WAIT   = 3'd2,
        FIX    = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t          state;
    logic [CW-1:0]   wait_cnt;
    logic            sign_a;
    logic            sign_b;
    logic            accept;
    logic            neg_a;
    logic            neg_b;

    assign accept = op_valid & ~flush & ~core_busy;
    assign neg_a  = rs_val[31] & op_signed;
    assign neg_b  = rt_val[31] & op_signed;

    // Gated by reset so that every output reads 0 while reset is held, even with op_valid high.
    assign stall = reset & (((state == IDLE) & op_valid & ~flush) |
                            (state == LAUNCH) | (state == WAIT) | (state == FIX));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            wait_cnt      <= '0;
            sign_a        <= 1'b0;
            sign_b        <= 1'b0;
            core_start    <= 1'b0;
            core_dividend <= '0;
            core_divisor  <= '0;
            hilo_we       <= 1'b0;
            div_err       <= 1'b0;
            hi_out        <= '0;
            lo_out        <= '0;
        end else begin
            core_start <= 1'b0;
            hilo_we    <= 1'b0;
            div_err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        sign_a        <= neg_a;
                        sign_b        <= neg_b;
                        core_dividend <= neg_a ? (~rs_val + 32'd1) : rs_val;
                        core_divisor  <= neg_b ? (~rt_val + 32'd1) : rt_val;
                        if (rt_val == 32'd0) begin
                            // Divide by zero bypasses the core entirely.
                            state   <= DONE;
                            hilo_we <= 1'b1;
                            hi_out  <= '0;
                            lo_out  <= '0;
                        end else begin
                            state      <= LAUNCH;
                            core_start <= 1'b1;
                        end
                    end
                end
                LAUNCH: begin
                    wait_cnt <= '0;
                    state    <= flush ? IDLE : WAIT;
                end
                WAIT: begin
                    wait_cnt <= wait_cnt + CW'(1);
                    if (flush) begin
                        state <= IDLE;
                    end else if (!core_busy) begin
                        state <= FIX;
                    end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
                        state   <= DONE;
                        hilo_we <= 1'b1;
                        div_err <= 1'b1;
                        hi_out  <= '0;
                        lo_out  <= '0;
                    end
                end
                FIX: begin
                    if (flush) begin
                        state <= IDLE;
                    end else begin
                        lo_out  <= (sign_a ^ sign_b) ? (~core_q + 32'd1) : core_q;
                        hi_out  <= sign_a ? (~core_r + 32'd1) : core_r;
                        hilo_we <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// tb/tb_div_seq_ctrl.sv - self-checking bench for div_seq_ctrl with a behavioural divider core
module tb_div_seq_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        op_valid;
    logic        op_signed;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        flush;
    logic        core_start;
    logic [31:0] core_dividend;
    logic [31:0] core_divisor;
    logic        core_busy = 1'b0;
    logic [31:0] core_q = '0;
    logic [31:0] core_r = '0;
    logic        stall;
    logic        hilo_we;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic        div_err;

    logic        hang;
    int          busy_left = 0;
    int          checks = 0;
    int          errors = 0;

    div_seq_ctrl #(.TIMEOUT(40)) dut (
        .clock(clock), .reset(reset), .op_valid(op_valid), .op_signed(op_signed),
        .rs_val(rs_val), .rt_val(rt_val), .flush(flush), .core_start(core_start),
        .core_dividend(core_dividend), .core_divisor(core_divisor), .core_busy(core_busy),
        .core_q(core_q), .core_r(core_r), .stall(stall), .hilo_we(hilo_we),
        .hi_out(hi_out), .lo_out(lo_out), .div_err(div_err)
    );

    always #5 clock = ~clock;

    // Divider core: busy for 32 cycles after the start pulse, or forever while hang is set.
    always @(posedge clock) begin
        if (core_start) begin
            core_busy <= 1'b1;
            busy_left <= 31;
            core_q    <= core_dividend / core_divisor;
            core_r    <= core_dividend % core_divisor;
        end else if (core_busy) begin
            if (busy_left != 0) busy_left <= busy_left - 1;
            else if (!hang) core_busy <= 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] mag(input bit sgn, input logic [31:0] v);
        longint x;
        x = sgn ? longint'($signed(v)) : longint'(v);
        if (x < 0) x = -x;
        return x[31:0];
    endfunction

    task automatic ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] lo, output logic [31:0] hi);
        longint sa, sb, q, r;
        if (b == 32'd0) begin
            lo = '0;
            hi = '0;
        end else begin
            sa = sgn ? longint'($signed(a)) : longint'(a);
            sb = sgn ? longint'($signed(b)) : longint'(b);
            q  = sa / sb;
            r  = sa % sb;
            lo = q[31:0];
            hi = r[31:0];
        end
    endtask

    task automatic run_op(input string tag, input bit sgn, input logic [31:0] a,
                          input logic [31:0] b, input bit exp_err, input int exp_lat);
        logic [31:0] elo, ehi;
        int n, starts;
        bit done, stall_ok;
        ref_div(sgn, a, b, elo, ehi);
        if (exp_err) begin
            elo = '0;
            ehi = '0;
        end
        op_valid = 1'b1; op_signed = sgn; rs_val = a; rt_val = b;
        #1;
        n = 0; starts = 0; done = 0; stall_ok = stall;
        while (!done && n < 200) begin
            step();
            n++;
            if (core_start) begin
                starts++;
                chk({tag, " dividend"}, core_dividend, mag(sgn, a));
                chk({tag, " divisor"}, core_divisor, mag(sgn, b));
            end
            if (hilo_we) begin
                done = 1;
                chk({tag, " lo"}, lo_out, elo);
                chk({tag, " hi"}, hi_out, ehi);
                chk({tag, " div_err"}, 32'(div_err), 32'(exp_err));
                chk({tag, " stall_done"}, 32'(stall), 32'd0);
                if (exp_lat >= 0) chk({tag, " latency"}, 32'(n), 32'(exp_lat));
            end else if (!stall) begin
                stall_ok = 0;
            end
        end
        op_valid = 1'b0;
        chk({tag, " completed"}, 32'(done), 32'd1);
        chk({tag, " stall_held"}, 32'(stall_ok), 32'd1);
        chk({tag, " starts"}, 32'(starts), (b == 32'd0) ? 32'd0 : 32'd1);
        step();
        chk({tag, " we_one_cycle"}, 32'(hilo_we), 32'd0);
    endtask

    initial begin
        bit          sg;
        logic [31:0] ra, rb;
        reset = 1'b0; op_valid = 1'b0; op_signed = 1'b0; rs_val = '0; rt_val = '0;
        flush = 1'b0; hang = 1'b0;
        repeat (3) step();
        chk("rst core_start", 32'(core_start), 32'd0);
        chk("rst stall", 32'(stall), 32'd0);
        chk("rst hilo_we", 32'(hilo_we), 32'd0);
        chk("rst div_err", 32'(div_err), 32'd0);
        chk("rst hi", hi_out, 32'd0);
        chk("rst lo", lo_out, 32'd0);
        chk("rst dividend", core_dividend, 32'd0);
        reset = 1'b1;
        step();

        run_op("divu_100_7", 0, 32'd100, 32'd7, 0, 36);
        run_op("div_m7_2", 1, 32'hFFFF_FFF9, 32'd2, 0, 36);
        run_op("div_7_m2", 1, 32'd7, 32'hFFFF_FFFE, 0, 36);
        run_op("div_ovf", 1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 36);
        run_op("divu_5_0", 0, 32'd5, 32'd0, 0, 1);
        run_op("divu_big", 0, 32'hFFFF_FFFF, 32'h8000_0000, 0, 36);

        // Flush during WAIT, then a back-to-back op that must wait for the core to go idle.
        op_valid = 1'b1; op_signed = 1'b0; rs_val = 32'd1000; rt_val = 32'd3;
        repeat (11) step();
        chk("flush pre_stall", 32'(stall), 32'd1);
        flush = 1'b1; op_valid = 1'b0;
        step();
        flush = 1'b0;
        #1;
        chk("flush stall", 32'(stall), 32'd0);
        chk("flush hilo_we", 32'(hilo_we), 32'd0);
        run_op("b2b_77_5", 0, 32'd77, 32'd5, 0, 58);

        // Core that never finishes.
        hang = 1'b1;
        run_op("timeout", 0, 32'd50, 32'd7, 1, 42);
        hang = 1'b0;
        repeat (3) step();
        chk("timeout idle stall", 32'(stall), 32'd0);

        // Asynchronous reset in the middle of WAIT.
        op_valid = 1'b1; op_signed = 1'b0; rs_val = 32'd1000; rt_val = 32'd7;
        repeat (6) step();
        #2 reset = 1'b0;
        #1;
        chk("mid_rst stall", 32'(stall), 32'd0);
        chk("mid_rst core_start", 32'(core_start), 32'd0);
        chk("mid_rst hilo_we", 32'(hilo_we), 32'd0);
        chk("mid_rst div_err", 32'(div_err), 32'd0);
        chk("mid_rst hi", hi_out, 32'd0);
        chk("mid_rst lo", lo_out, 32'd0);
        chk("mid_rst dividend", core_dividend, 32'd0);
        chk("mid_rst divisor", core_divisor, 32'd0);
        op_valid = 1'b0;
        repeat (2) step();
        reset = 1'b1;
        run_op("post_rst_9_3", 0, 32'd9, 32'd3, 0, -1);
        repeat (40) step();

        for (int i = 0; i < 24; i++) begin
            sg = 1'($urandom_range(0, 1));
            ra = $urandom;
            if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1:       rb = 32'hFFFF_FFFF;
                2:       rb = 32'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            run_op($sformatf("rand%0d", i), sg, ra, rb, 0, (rb == 32'd0) ? 1 : 36);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
